// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker; prio_i names the port that wins a tie.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic       valid_o,
  output logic       owner_o
);

  // Single requester wins outright; on a tie the priority port wins.
  always_comb begin
    valid_o = |req_i;
    owner_o = OWN_M0;
    case (req_i)
      2'b01:   owner_o = OWN_M0;
      2'b10:   owner_o = OWN_M1;
      2'b11:   owner_o = prio_i;
      default: owner_o = OWN_M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between two masters: grant, address issue,
// fixed-latency read wait, response pulse. All outputs are registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              arb_valid;
  logic              arb_owner;

  arb_rr2 u_arb (
    .req_i   ({m1_req_i, m0_req_i}),
    .prio_i  (prio_q),
    .valid_o (arb_valid),
    .owner_o (arb_owner)
  );

  // State and datapath registers; reset drops any in-flight read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prio_q      <= OWN_M0;
      owner_q     <= OWN_M0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic; during ISSUE mem_we_q tells a write from a read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) state_d = ISSUE;
        else           state_d = IDLE;
      end
      ISSUE: begin
        if (mem_we_q) state_d = IDLE;
        else          state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             state_d = WAIT;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and priority.
  always_comb begin
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d = arb_owner;
          if (arb_owner == OWN_M1) begin
            gnt_d       = 2'b10;
            mem_we_d    = m1_we_i;
            mem_addr_d  = m1_addr_i;
            mem_wdata_d = m1_wdata_i;
          end else begin
            gnt_d       = 2'b01;
            mem_we_d    = m0_we_i;
            mem_addr_d  = m0_addr_i;
            mem_wdata_d = m0_wdata_i;
          end
        end else begin
          owner_d = owner_q;
        end
      end
      ISSUE: begin
        prio_d = ~owner_q;
        cnt_d  = LAT_M1;
      end
      WAIT: begin
        // Counter at zero marks the cycle in which mem_rdata is valid.
        if (cnt_q == '0) begin
          if (owner_q == OWN_M1) begin
            rdata1_d = mem_rdata_i;
            rvalid_d = 2'b10;
          end else begin
            rdata0_d = mem_rdata_i;
            rvalid_d = 2'b01;
          end
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP:    cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  assign m0_gnt_o    = gnt_q[0];
  assign m1_gnt_o    = gnt_q[1];
  assign m0_rvalid_o = rvalid_q[0];
  assign m1_rvalid_o = rvalid_q[1];
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
